// File: rtl/rom_pkg.sv
//==============================================================================
// Module  : rom_pkg
// Purpose : Shared definitions for the rom burst reader: default rom geometry
//           and the reader FSM state encoding.
// Ports   : none (package)
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package rom_pkg;

  // Default rom geometry: depth = 2**DEF_ADDR_W words of DEF_DATA_W bits.
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 4;

  // Reader FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rom_stream_reader.sv
//==============================================================================
// Module  : rom_stream_reader
// Purpose : Burst address generator and registered output stage for an
//           external combinational rom. A start pulse walks len consecutive
//           addresses from base (modulo 2**ADDR_W) and presents each word on a
//           valid/ready stream with backpressure.
// Ports   :
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous active-high reset
//   start      in   1        burst request (sampled in IDLE only)
//   base       in   ADDR_W   first address of the burst
//   len        in   LEN_W    number of words (0 = empty burst)
//   rom_addr   out  ADDR_W   address to the rom
//   rom_data   in   DATA_W   rom word for rom_addr (same cycle)
//   data_out   out  DATA_W   registered rom word
//   data_addr  out  ADDR_W   address data_out came from
//   data_valid out  1        data_out/data_addr valid
//   data_ready in   1        consumer accepts on valid && ready
//   busy       out  1        burst in progress
//   done       out  1        one-cycle pulse at end of burst
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module rom_stream_reader
  import rom_pkg::*;
#(
  parameter int   ADDR_W = DEF_ADDR_W,
  parameter int   DATA_W = DEF_DATA_W,
  localparam int  LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] data_addr,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              done
);

  // Registered state
  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_rem;
  logic [DATA_W-1:0]   r_data;
  logic [ADDR_W-1:0]   r_daddr;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;

  // Next-state values
  state_t              w_state;
  logic [ADDR_W-1:0]   w_addr;
  logic [LEN_W-1:0]    w_rem;
  logic [DATA_W-1:0]   w_data;
  logic [ADDR_W-1:0]   w_daddr;
  logic                w_valid;
  logic                w_busy;
  logic                w_done;

  // The output register may be (re)loaded when empty or when its word is
  // being taken this edge; otherwise the consumer is stalling us.
  logic                w_can_capture;
  logic                w_handshake;

  assign w_can_capture = !r_valid || data_ready;
  assign w_handshake   = r_valid && data_ready;

  always_comb begin
    w_state = r_state;
    w_addr  = r_addr;
    w_rem   = r_rem;
    w_data  = r_data;
    w_daddr = r_daddr;
    w_valid = r_valid;
    w_busy  = r_busy;
    w_done  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            w_addr  = base;
            w_rem   = len;
            w_busy  = 1'b1;
            w_state = ST_RUN;
          end else begin
            // Empty burst: acknowledge immediately without going busy.
            w_done = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (w_can_capture) begin
          w_data  = rom_data;
          w_daddr = r_addr;
          w_valid = 1'b1;
          // Natural overflow of the ADDR_W-bit add provides the wrap.
          w_addr  = r_addr + ADDR_W'(1);
          w_rem   = r_rem - LEN_W'(1);
          if (r_rem == LEN_W'(1)) begin
            w_state = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        // Final word is in the output register; finish once it is taken.
        if (w_handshake) begin
          w_valid = 1'b0;
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_state = ST_IDLE;
        end
      end

      default: begin
        w_state = ST_IDLE;
        w_valid = 1'b0;
        w_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_data  <= '0;
      r_daddr <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_addr  <= w_addr;
      r_rem   <= w_rem;
      r_data  <= w_data;
      r_daddr <= w_daddr;
      r_valid <= w_valid;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign rom_addr   = r_addr;
  assign data_out   = r_data;
  assign data_addr  = r_daddr;
  assign data_valid = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
//==============================================================================
// Module  : tb_rom_stream_reader
// Purpose : Directed self-checking bench for rom_stream_reader with an 8x4
//           combinational rom model attached to rom_addr/rom_data.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rom_stream_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] base = 3'd0;
  logic [3:0] len = 4'd0;
  logic       data_ready = 1'b1;
  logic [2:0] rom_addr;
  logic [3:0] rom_data;
  logic [3:0] data_out;
  logic [2:0] data_addr;
  logic       data_valid;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  // Results of the most recent collect() call
  logic [2:0] cap_addr [0:31];
  logic [3:0] cap_data [0:31];
  int         cap_n;
  int         first_cyc;
  int         done_cyc;
  logic       hold_bad;

  always #5 clk = ~clk;

  // rom contents
  function automatic logic [3:0] rom_word(input logic [2:0] a);
    case (a)
      3'd0: return 4'hA;
      3'd1: return 4'h3;
      3'd2: return 4'h7;
      3'd3: return 4'hC;
      3'd4: return 4'h1;
      3'd5: return 4'hF;
      3'd6: return 4'h5;
      default: return 4'h9;
    endcase
  endfunction

  assign rom_data = rom_word(rom_addr);

  rom_stream_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base       (base),
    .len        (len),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .data_out   (data_out),
    .data_addr  (data_addr),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .done       (done)
  );

  // One-cycle start pulse; returns 1ns after the accepting edge (E0).
  task automatic start_burst(input logic [2:0] b, input logic [3:0] l);
    start = 1'b1;
    base  = b;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs the stream until done (or max_c cycles). Cycle c counts edges after
  // E0. Stalls word stall_idx for stall_n cycles; injects a start with
  // base=5,len=3 at cycle ghost_c. Returns 1ns after the done edge.
  task automatic collect(input int max_c, input int stall_idx,
                         input int stall_n, input int ghost_c);
    int         c;
    int         left;
    logic       snap_ok;
    logic [3:0] sd;
    logic [2:0] sa;
    logic [2:0] sr;
    c = 0; left = stall_n; snap_ok = 1'b0; sd = '0; sa = '0; sr = '0;
    cap_n = 0; first_cyc = -1; done_cyc = -1; hold_bad = 1'b0;
    while (c < max_c && done_cyc < 0) begin
      if (c == ghost_c) begin
        start = 1'b1; base = 3'd5; len = 4'd3;
      end else begin
        start = 1'b0;
      end
      if (data_valid && first_cyc < 0) first_cyc = c;
      if (data_valid && cap_n == stall_idx && left > 0) begin
        data_ready = 1'b0;
        left--;
        if (snap_ok && (data_out !== sd || data_addr !== sa || rom_addr !== sr))
          hold_bad = 1'b1;
        sd = data_out; sa = data_addr; sr = rom_addr; snap_ok = 1'b1;
      end else begin
        data_ready = 1'b1;
      end
      if (data_valid && data_ready && cap_n < 32) begin
        cap_addr[cap_n] = data_addr;
        cap_data[cap_n] = data_out;
        cap_n++;
      end
      @(posedge clk); #1;
      c++;
      if (done === 1'b1) done_cyc = c;
    end
    start = 1'b0;
    data_ready = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({data_valid, busy, done, rom_addr, data_out, data_addr} !== 16'd0) begin
      n_err++;
      $display("FAIL reset_initial: got %h expected 0",
               {data_valid, busy, done, rom_addr, data_out, data_addr});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    start_burst(3'd5, 4'd3);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({data_valid, busy, done, rom_addr, data_out, data_addr} !== 16'd0) begin
      n_err++;
      $display("FAIL reset_async: got %h expected 0",
               {data_valid, busy, done, rom_addr, data_out, data_addr});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({data_valid, busy, done} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_after: got %b expected 000", {data_valid, busy, done});
    end
  endtask

  task automatic test_full_sweep();
    start_burst(3'd0, 4'd8);
    n_vec++;
    if (rom_addr !== 3'd0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL sweep_accept: got addr=%0d busy=%b expected addr=0 busy=1",
               rom_addr, busy);
    end
    collect(40, -1, 0, -1);
    n_vec++;
    if (cap_n != 8) begin
      n_err++;
      $display("FAIL sweep_count: got %0d expected 8", cap_n);
    end
    for (int i = 0; i < 8 && i < cap_n; i++) begin
      n_vec++;
      if (cap_addr[i] !== 3'(i) || cap_data[i] !== rom_word(3'(i))) begin
        n_err++;
        $display("FAIL sweep_word%0d: got addr=%0d data=%h expected addr=%0d data=%h",
                 i, cap_addr[i], cap_data[i], i, rom_word(3'(i)));
      end
    end
    n_vec++;
    if (first_cyc != 1 || done_cyc != 9) begin
      n_err++;
      $display("FAIL sweep_timing: got first=%0d done=%0d expected first=1 done=9",
               first_cyc, done_cyc);
    end
    n_vec++;
    if (busy !== 1'b0 || data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL sweep_end: got busy=%b valid=%b expected 0 0", busy, data_valid);
    end
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL sweep_done_width: got done=%b expected 0", done);
    end
  endtask

  task automatic test_wrap();
    logic [2:0] exp_a [0:3];
    exp_a[0] = 3'd6; exp_a[1] = 3'd7; exp_a[2] = 3'd0; exp_a[3] = 3'd1;
    start_burst(3'd6, 4'd4);
    collect(40, -1, 0, -1);
    n_vec++;
    if (cap_n != 4 || done_cyc != 5) begin
      n_err++;
      $display("FAIL wrap_count: got n=%0d done=%0d expected n=4 done=5", cap_n, done_cyc);
    end
    for (int i = 0; i < 4 && i < cap_n; i++) begin
      n_vec++;
      if (cap_addr[i] !== exp_a[i] || cap_data[i] !== rom_word(exp_a[i])) begin
        n_err++;
        $display("FAIL wrap_word%0d: got addr=%0d data=%h expected addr=%0d data=%h",
                 i, cap_addr[i], cap_data[i], exp_a[i], rom_word(exp_a[i]));
      end
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_backpressure();
    start_burst(3'd2, 4'd3);
    collect(40, 1, 3, -1);
    n_vec++;
    if (cap_n != 3 || done_cyc != 7) begin
      n_err++;
      $display("FAIL bp_count: got n=%0d done=%0d expected n=3 done=7", cap_n, done_cyc);
    end
    for (int i = 0; i < 3 && i < cap_n; i++) begin
      n_vec++;
      if (cap_addr[i] !== 3'(i + 2) || cap_data[i] !== rom_word(3'(i + 2))) begin
        n_err++;
        $display("FAIL bp_word%0d: got addr=%0d data=%h expected addr=%0d data=%h",
                 i, cap_addr[i], cap_data[i], i + 2, rom_word(3'(i + 2)));
      end
    end
    n_vec++;
    if (hold_bad !== 1'b0) begin
      n_err++;
      $display("FAIL bp_hold: got unstable=%b expected 0", hold_bad);
    end
  endtask

  task automatic test_edge_cases();
    // Empty burst
    start_burst(3'd4, 4'd0);
    n_vec++;
    if ({done, busy, data_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL len0_done: got done/busy/valid=%b expected 100", {done, busy, data_valid});
    end
    @(posedge clk); #1;
    n_vec++;
    if ({done, busy, data_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL len0_after: got done/busy/valid=%b expected 000", {done, busy, data_valid});
    end

    // Start while busy is ignored
    start_burst(3'd0, 4'd2);
    collect(40, -1, 0, 0);
    n_vec++;
    if (cap_n != 2 || done_cyc != 3 || cap_addr[0] !== 3'd0 || cap_addr[1] !== 3'd1) begin
      n_err++;
      $display("FAIL busy_start: got n=%0d done=%0d a0=%0d a1=%0d expected n=2 done=3 a0=0 a1=1",
               cap_n, done_cyc, cap_addr[0], cap_addr[1]);
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, data_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL busy_start_idle: got busy/valid=%b expected 00", {busy, data_valid});
    end

    // Start on the done cycle
    start_burst(3'd3, 4'd1);
    collect(40, -1, 0, -1);
    n_vec++;
    if (cap_n != 1 || done_cyc != 2 || cap_data[0] !== rom_word(3'd3)) begin
      n_err++;
      $display("FAIL chain_first: got n=%0d done=%0d data=%h expected n=1 done=2 data=%h",
               cap_n, done_cyc, cap_data[0], rom_word(3'd3));
    end
    start_burst(3'd7, 4'd2);
    n_vec++;
    if (rom_addr !== 3'd7 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL chain_accept: got addr=%0d busy=%b expected addr=7 busy=1", rom_addr, busy);
    end
    collect(40, -1, 0, -1);
    n_vec++;
    if (cap_n != 2 || done_cyc != 3 || cap_addr[0] !== 3'd7 || cap_addr[1] !== 3'd0
        || cap_data[1] !== rom_word(3'd0)) begin
      n_err++;
      $display("FAIL chain_second: got n=%0d done=%0d a0=%0d a1=%0d d1=%h expected 2 3 7 0 %h",
               cap_n, done_cyc, cap_addr[0], cap_addr[1], cap_data[1], rom_word(3'd0));
    end
  endtask

  task automatic test_reset_mid_burst();
    logic saw_done;
    saw_done = 1'b0;
    start_burst(3'd0, 4'd8);
    collect(4, -1, 0, -1);
    n_vec++;
    if (cap_n != 3 || done_cyc != -1) begin
      n_err++;
      $display("FAIL midrst_pre: got n=%0d done=%0d expected n=3 done=-1", cap_n, done_cyc);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({data_valid, busy, done, rom_addr, data_out, data_addr} !== 16'd0) begin
      n_err++;
      $display("FAIL midrst_clear: got %h expected 0",
               {data_valid, busy, done, rom_addr, data_out, data_addr});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (done === 1'b1 || busy === 1'b1 || data_valid === 1'b1) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    n_vec++;
    if (saw_done !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_quiet: got activity=%b expected 0", saw_done);
    end
    start_burst(3'd5, 4'd2);
    collect(40, -1, 0, -1);
    n_vec++;
    if (cap_n != 2 || done_cyc != 3 || cap_addr[0] !== 3'd5 || cap_addr[1] !== 3'd6
        || cap_data[0] !== rom_word(3'd5)) begin
      n_err++;
      $display("FAIL midrst_restart: got n=%0d done=%0d a0=%0d a1=%0d d0=%h expected 2 3 5 6 %h",
               cap_n, done_cyc, cap_addr[0], cap_addr[1], cap_data[0], rom_word(3'd5));
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_wrap();
    test_backpressure();
    test_edge_cases();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
